mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
Sequencer for the 2D MAC array built from stacked mac_row instances. It accepts a job (kernel-load length, execute length, dataflow mode), drives the per-row 2-bit instruction bus with one cycle of skew per row, issues read strobes to the L0 input buffer, drains the array pipeline, and signals completion. It sits between the top-level core FSM and the array/L0.

Parameters:
row, 8, number of mac_row instances (array height)
col, 8, MAC tiles per row (array width)
len_bw, 8, width of the load/execute length fields

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  job request; accepted only when ready=1
mode_sel_in  input  1  dataflow mode for the job (0 weight-stationary, 1 output-stationary)
load_len  input  len_bw  kernel-load cycles for the job
exec_len  input  len_bw  execute cycles for the job
abort  input  1  synchronous job cancel
ready  output  1  idle and able to accept start
busy  output  1  job in progress (LOAD, EXEC or DRAIN)
done  output  1  one-cycle completion pulse
mode_sel  output  1  latched mode, to every mac_row
l0_rd  output  1  L0 read strobe, aligned with row 0 instruction
inst_w  output  2*row  row r instruction at [2r+1:2r]; bit1 execute, bit0 kernel load

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; ready=1; busy=0, done=0, mode_sel=0, l0_rd=0; inst_w all 0; counters 0; skew chain cleared. Reset mid-job drops the job with no done pulse.
- States: IDLE, LOAD, EXEC, DRAIN, DONE. All outputs decode from registered state or registers, with no combinational path from inputs to outputs.
- IDLE: ready=1. At the edge where start=1, the block latches mode_sel_in, load_len and exec_len. mode_sel updates at that edge. Next state is LOAD if load_len!=0 and mode=0; else EXEC if exec_len!=0; else DRAIN.
- LOAD: base instruction 2'b01, l0_rd=1, for exactly load_len cycles. Then EXEC if exec_len!=0, else DRAIN.
- EXEC: base instruction 2'b10, l0_rd=1, for exactly exec_len cycles. Then DRAIN.
- DRAIN: base instruction 2'b00, l0_rd=0, for exactly (row-1)+col cycles, covering skew plus east-ward propagation. Then DONE.
- DONE: done=1 for one cycle, busy=0. Next state IDLE.
- busy=1 in LOAD, EXEC and DRAIN only. ready=1 in IDLE only.
- Load is skipped when mode=1. In output-stationary mode no kernel is loaded and load_len is ignored.
- Skew: row 0 gets the base instruction in the first cycle of the state. Row r gets the row 0 value delayed r cycles through a register chain. With start accepted at edge T, row 0 shows 01 at cycles T+1..T+load_len, and row r is shifted by r.
- Counters count down from len-1 to 0. The state transitions on the edge where the count is 0. Lengths are unsigned, max 2^len_bw-1.
- start outside IDLE is ignored; no queueing.
- abort=1 in LOAD, EXEC or DRAIN: next state IDLE, with no done pulse. The whole skew chain is flushed to 00 on the same edge and l0_rd=0. abort in IDLE or DONE has no effect; a DONE pulse still completes.
- start and abort together in IDLE: start is accepted.
- mode_sel holds the latched value until the next accepted start.

Decomposition:
- Package mac_ctrl_pkg holds:
  - state enum (IDLE, LOAD, EXEC, DRAIN, DONE)
  - instruction constants INST_NOP=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10
  - DRAIN length function of row and col
- Sub-module inst_skew (param row): a 2-bit-wide, row-deep shift chain with synchronous flush and asynchronous active-low reset. It produces inst_w from the base instruction.

Test Plan:
1. Reset mid-EXEC (reset=0 asynchronously) -> inst_w=0, l0_rd=0, busy=0, ready=1 immediately; no done pulse.
2. start with mode=0, load_len=8, exec_len=16 at edge T:
   - row 0 shows 01 at T+1..T+8 and 10 at T+9..T+24.
   - row 7 shows the same pattern shifted by 7.
   - l0_rd high for 24 cycles.
   - done pulses at T+40 (24 + 15 drain + 1).
3. mode=1, load_len=5, exec_len=4 -> no 01 on any row; 10 for 4 cycles on row 0; mode_sel=1 held after done.
4. load_len=0, exec_len=0 -> IDLE to DRAIN directly; inst_w stays 0; done after 15 drain cycles.
5. abort at 3rd EXEC cycle -> next cycle all inst_w=00, l0_rd=0, ready=1, no done. A start issued during the job before the abort is ignored.
6. Back-to-back jobs: start held high through DONE -> second job accepted the cycle ready rises; its latched lengths are independent of the first job.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC array sequencer.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Drain covers the row skew plus east-ward propagation across the row.
  function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
    return rows - 1 + cols;
  endfunction

endpackage

// File: rtl/inst_skew.sv
// Row-skew shift chain: row 0 is the base instruction, row r is row 0 delayed r cycles.
module inst_skew #(
  parameter int unsigned row = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       base,
  output logic [2*row-1:0] inst_w
);

  logic [2*row-1:2] dly;

  always_comb begin
    inst_w = {dly, base};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly <= '0;
    end else if (flush) begin
      dly <= '0;
    end else begin
      dly <= inst_w[2*row-3:0];
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the MAC array: LOAD/EXEC/DRAIN with per-row instruction skew.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_sel_in,
  input  logic [len_bw-1:0] load_len,
  input  logic [len_bw-1:0] exec_len,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              mode_sel,
  output logic              l0_rd,
  output logic [2*row-1:0]  inst_w
);

  localparam int unsigned DRAIN_CYC = drain_len(row, col);
  localparam int unsigned DRAIN_BW  = $clog2(DRAIN_CYC + 1);
  localparam int unsigned CW        = (len_bw > DRAIN_BW) ? len_bw : DRAIN_BW;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [len_bw-1:0] exec_len_q;
  logic              accept;
  logic              flush;
  logic [1:0]        base;

  always_comb begin
    accept = (state == IDLE) && start;
    flush  = abort && ((state == LOAD) || (state == EXEC) || (state == DRAIN));
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          if ((load_len != '0) && !mode_sel_in) begin
            state_n = LOAD;
            cnt_n   = CW'(load_len) - CW'(1);
          end else if (exec_len != '0) begin
            state_n = EXEC;
            cnt_n   = CW'(exec_len) - CW'(1);
          end else begin
            state_n = DRAIN;
            cnt_n   = CW'(DRAIN_CYC - 1);
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          if (exec_len_q != '0) begin
            state_n = EXEC;
            cnt_n   = CW'(exec_len_q) - CW'(1);
          end else begin
            state_n = DRAIN;
            cnt_n   = CW'(DRAIN_CYC - 1);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      EXEC: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = DRAIN;
          cnt_n   = CW'(DRAIN_CYC - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      exec_len_q <= '0;
      mode_sel   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        exec_len_q <= exec_len;
        mode_sel   <= mode_sel_in;
      end
    end
  end

  // Row 0 and l0_rd decode straight from the state register so they line up.
  always_comb begin
    base  = INST_NOP;
    l0_rd = 1'b0;
    if (state == LOAD) begin
      base  = INST_LOAD;
      l0_rd = 1'b1;
    end else if (state == EXEC) begin
      base  = INST_EXEC;
      l0_rd = 1'b1;
    end
    ready = (state == IDLE);
    busy  = (state == LOAD) || (state == EXEC) || (state == DRAIN);
    done  = (state == DONE);
  end

  inst_skew #(.row(row)) u_skew (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .base   (base),
    .inst_w (inst_w)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl against a per-job timeline model.
module tb_mac_array_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int LBW  = 8;
  localparam int D    = ROW - 1 + COL;
  localparam int HMAX = 8192;

  logic             clk;
  logic             reset;
  logic             start;
  logic             mode_sel_in;
  logic [LBW-1:0]   load_len;
  logic [LBW-1:0]   exec_len;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic             mode_sel;
  logic             l0_rd;
  logic [2*ROW-1:0] inst_w;

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_sel_in (mode_sel_in),
    .load_len    (load_len),
    .exec_len    (exec_len),
    .abort       (abort),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .mode_sel    (mode_sel),
    .l0_rd       (l0_rd),
    .inst_w      (inst_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row-0 instruction expected in each cycle; row r reads it r cycles later.
  logic [1:0] hist [0:HMAX-1];
  int  cyc;
  int  job_a, job_end, job_done;
  bit  job_valid;
  logic mode_exp;
  int  n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic bit exp_ready(input int c);
    return !(job_valid && c >= job_a && c <= job_done);
  endfunction

  function automatic bit exp_busy(input int c);
    return job_valid && c >= job_a && c < job_done;
  endfunction

  function automatic bit exp_done(input int c);
    return job_valid && c == job_done;
  endfunction

  task automatic cancel_job();
    if (job_valid)
      for (int k = job_a; k < job_end && k < HMAX; k++) hist[k] = 2'b00;
    job_valid = 0;
  endtask

  task automatic check_all();
    logic [2*ROW-1:0] ei;
    ei = '0;
    for (int r = 0; r < ROW; r++)
      if (cyc - r >= 0) ei[2*r +: 2] = hist[cyc - r];
    check("inst_w", 32'(inst_w), 32'(ei));
    check("l0_rd", 32'(l0_rd), 32'(hist[cyc] != 2'b00));
    check("ready", 32'(ready), 32'(exp_ready(cyc)));
    check("busy", 32'(busy), 32'(exp_busy(cyc)));
    check("done", 32'(done), 32'(exp_done(cyc)));
    check("mode_sel", 32'(mode_sel), 32'(mode_exp));
  endtask

  task automatic step(input logic s, input logic m, input logic [LBW-1:0] ll,
                      input logic [LBW-1:0] el, input logic ab);
    int a, l, e;
    start = s; mode_sel_in = m; load_len = ll; exec_len = el; abort = ab;
    if (ab && exp_busy(cyc)) begin
      cancel_job();
    end else if (s && exp_ready(cyc)) begin
      a = cyc + 1;
      l = m ? 0 : int'(ll);
      e = int'(el);
      for (int k = a; k < a + l; k++) hist[k] = 2'b01;
      for (int k = a + l; k < a + l + e; k++) hist[k] = 2'b10;
      job_a = a; job_end = a + l + e; job_done = a + l + e + D;
      job_valid = 1; mode_exp = m;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_inst_w", 32'(inst_w), 32'd0);
    check("rst_l0_rd", 32'(l0_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    cancel_job();
    mode_exp = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    job_valid = 0; job_a = 0; job_end = 0; job_done = 0; mode_exp = 1'b0;
    for (int k = 0; k < HMAX; k++) hist[k] = 2'b00;
    reset = 1'b0; start = 1'b0; mode_sel_in = 1'b0;
    load_len = '0; exec_len = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // weight-stationary 8/16
    step(1'b1, 1'b0, 8'd8, 8'd16, 1'b0);
    idle(45);
    // output-stationary ignores load_len
    step(1'b1, 1'b1, 8'd5, 8'd4, 1'b0);
    idle(25);
    // empty job goes straight to drain
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    idle(20);
    // ignored start during job, then abort in the 3rd EXEC cycle
    step(1'b1, 1'b0, 8'd3, 8'd10, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 8'd9, 8'd9, 1'b0);
    idle(3);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    idle(20);
    // asynchronous reset mid-EXEC
    step(1'b1, 1'b0, 8'd2, 8'd10, 1'b0);
    idle(4);
    async_reset();
    idle(20);
    // back-to-back: start held through DONE with new lengths
    step(1'b1, 1'b0, 8'd2, 8'd3, 1'b0);
    repeat (30) step(1'b1, 1'b0, 8'd4, 8'd5, 1'b0);
    idle(30);
    // start and abort together in IDLE
    step(1'b1, 1'b0, 8'd1, 8'd1, 1'b1);
    idle(25);

    for (int i = 0; i < 2500; i++) begin
      logic s, m, ab;
      logic [LBW-1:0] ll, el;
      s  = ($urandom_range(0, 3) == 0);
      m  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 39) == 0);
      ll = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      el = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      step(s, m, ll, el, ab);
    end
    idle(600);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
